timer_wakeup_capture: RTL and testbench

//  Consumer side of the 20-bit wakeup timer. Samples the timer's mixed-code count and its

---
 rtl/timer_wakeup_capture_if.sv | 10 +
 rtl/timer_wakeup_capture.sv | 128 ++++++++++++
 tb/tb_timer_wakeup_capture.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_wakeup_capture_if.sv
// Timestamp stream between the wakeup capture block and its downstream reader.
interface timer_wakeup_capture_if;
  logic [19:0] ts_data;
  logic [19:0] ts_delta;
  logic        ts_valid;
  logic        ts_ready;

  modport master (output ts_data, output ts_delta, output ts_valid, input ts_ready);
  modport slave  (input ts_data, input ts_delta, input ts_valid, output ts_ready);
endinterface

// File: rtl/timer_wakeup_capture.sv
// Samples the wakeup timer's mixed Gray/binary count, decodes it, and queues a
// timestamp plus elapsed-count delta on every enabled wakeup rising edge.
module timer_wakeup_capture #(
  parameter int DEPTH = 4,
  parameter int CW    = 20
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic [CW-1:0]            cnt_in,
  input  logic                     wakeup_in,
  timer_wakeup_capture_if.master   ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef logic [2*CW-1:0] entry_t;

  logic [CW-1:0] cnt_s_q, cnt_s_d;
  logic          wk_s_q, wk_s_d;
  logic          wk_p_q, wk_p_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [CW-1:0] last_bin_q, last_bin_d;
  logic          first_q, first_d;
  logic          overflow_q, overflow_d;

  logic [CW-1:0] bin;
  logic [CW-1:0] delta;
  logic          evt, full, pop, push, drop;

  // Gray nibbles decode MSB-down; the two top binary nibbles pass straight through.
  always_comb begin
    bin = cnt_s_q;
    for (int n = 0; n < 3; n++) begin
      for (int i = 2; i >= 0; i--) begin
        bin[4*n+i] = bin[4*n+i+1] ^ cnt_s_q[4*n+i];
      end
    end
  end

  assign evt   = wk_s_q & ~wk_p_q & en;
  assign full  = (count_q == LW'(DEPTH));
  assign pop   = ts.ts_valid & ts.ts_ready;
  assign push  = evt & (~full | pop);
  assign drop  = evt & full & ~pop;
  assign delta = first_q ? '0 : (bin - last_bin_q);

  always_comb begin
    cnt_s_d    = cnt_in;
    wk_s_d     = wakeup_in;
    wk_p_d     = wk_s_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_bin_d = last_bin_q;
    first_d    = first_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      first_d    = 1'b1;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {bin, delta};
        wr_ptr_d        = wr_ptr_q + AW'(1);
        last_bin_d      = bin;
        first_d         = 1'b0;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_s_q    <= '0;
      wk_s_q     <= 1'b0;
      wk_p_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_bin_q <= '0;
      first_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      cnt_s_q    <= cnt_s_d;
      wk_s_q     <= wk_s_d;
      wk_p_q     <= wk_p_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_bin_q <= last_bin_d;
      first_q    <= first_d;
      overflow_q <= overflow_d;
    end
  end

  assign ts.ts_valid = (count_q != '0);
  assign ts.ts_data  = mem_q[rd_ptr_q][2*CW-1:CW];
  assign ts.ts_delta = mem_q[rd_ptr_q][CW-1:0];
  assign level       = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_timer_wakeup_capture.sv
// Randomized and directed checks of timer_wakeup_capture against a queue-based
// reference model of the capture FIFO.
module tb_timer_wakeup_capture;

  localparam int DEPTH = 4;

  logic        clk;
  logic        clr_n;
  logic        en;
  logic        flush;
  logic [19:0] cnt_in;
  logic        wakeup_in;
  logic [2:0]  level;
  logic        overflow;

  timer_wakeup_capture_if ifc ();

  timer_wakeup_capture #(.DEPTH(DEPTH), .CW(20)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .en        (en),
    .flush     (flush),
    .cnt_in    (cnt_in),
    .wakeup_in (wakeup_in),
    .ts        (ifc),
    .level     (level),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compareCount;
  int mismatchCount;

  // Reference model: a queue of {timestamp, delta} plus a short history of sampled inputs.
  logic [39:0] modelQ [$];
  bit          smp1, smp2;
  logic [19:0] cntSmp;
  logic [19:0] lastBin;
  bit          firstEvt;
  bit          ovfModel;

  // Binary value of a Gray nibble is the XOR of all its right shifts.
  function automatic logic [19:0] decodeMixed(input logic [19:0] c);
    logic [19:0] r;
    logic [3:0]  g;
    r = c;
    for (int n = 0; n < 3; n++) begin
      g = c[4*n +: 4];
      r[4*n +: 4] = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    end
    return r;
  endfunction

  function automatic logic [19:0] toMixed(input logic [19:0] b);
    logic [19:0] r;
    logic [3:0]  v;
    r = b;
    for (int n = 0; n < 3; n++) begin
      v = b[4*n +: 4];
      r[4*n +: 4] = v ^ (v >> 1);
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    smp1     = 1'b0;
    smp2     = 1'b0;
    cntSmp   = '0;
    lastBin  = '0;
    firstEvt = 1'b1;
    ovfModel = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs applied before it.
  task automatic modelStep();
    bit          pop;
    bit          evt;
    int          lvl;
    logic [19:0] b;
    logic [19:0] d;
    pop = (modelQ.size() != 0) && ifc.ts_ready;
    evt = smp1 && !smp2 && en;
    b   = decodeMixed(cntSmp);
    if (flush) begin
      modelQ.delete();
      ovfModel = 1'b0;
      firstEvt = 1'b1;
    end else begin
      lvl = modelQ.size();
      if (pop) void'(modelQ.pop_front());
      if (evt) begin
        if (lvl == DEPTH && !pop) begin
          ovfModel = 1'b1;
        end else begin
          d = firstEvt ? 20'h0 : (b - lastBin);
          modelQ.push_back({b, d});
          lastBin  = b;
          firstEvt = 1'b0;
        end
      end
    end
    smp2   = smp1;
    smp1   = wakeup_in;
    cntSmp = cnt_in;
  endtask

  task automatic checkAll();
    checkOutput("valid", 32'(ifc.ts_valid), 32'(modelQ.size() != 0));
    checkOutput("level", 32'(level), 32'(modelQ.size()));
    checkOutput("overflow", 32'(overflow), 32'(ovfModel));
    if (modelQ.size() != 0) begin
      checkOutput("data", 32'(ifc.ts_data), 32'(modelQ[0][39:20]));
      checkOutput("delta", 32'(ifc.ts_delta), 32'(modelQ[0][19:0]));
    end
  endtask

  task automatic applyStimulus(input bit enV, input bit flushV, input logic [19:0] cntV,
                               input bit wkV, input bit rdyV);
    @(negedge clk);
    en           = enV;
    flush        = flushV;
    cnt_in       = cntV;
    wakeup_in    = wkV;
    ifc.ts_ready = rdyV;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic pulseWake(input logic [19:0] binV, input bit rdyPush);
    applyStimulus(1'b1, 1'b0, toMixed(binV), 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, toMixed(binV), 1'b1, rdyPush);
    applyStimulus(1'b1, 1'b0, toMixed(binV), 1'b0, 1'b0);
  endtask

  task automatic doFlush();
    applyStimulus(1'b1, 1'b1, 20'h0, 1'b0, 1'b0);
  endtask

  initial begin
    bit          wk;
    logic [19:0] b;
    compareCount  = 0;
    mismatchCount = 0;
    clr_n         = 1'b0;
    en            = 1'b0;
    flush         = 1'b0;
    cnt_in        = '0;
    wakeup_in     = 1'b0;
    ifc.ts_ready  = 1'b0;
    modelReset();
    #12;
    checkOutput("rst_valid", 32'(ifc.ts_valid), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_data", 32'(ifc.ts_data), 32'd0);
    checkOutput("rst_delta", 32'(ifc.ts_delta), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    // Decode and two-edge latency.
    applyStimulus(1'b1, 1'b0, 20'h12267, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 20'h12267, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 20'h12267, 1'b1, 1'b0);
    checkOutput("t1_not_yet", 32'(ifc.ts_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 20'h12267, 1'b1, 1'b0);
    checkOutput("t1_valid", 32'(ifc.ts_valid), 32'd1);
    checkOutput("t1_data", 32'(ifc.ts_data), 32'h12345);
    checkOutput("t1_delta", 32'(ifc.ts_delta), 32'h0);
    applyStimulus(1'b1, 1'b0, 20'h0, 1'b0, 1'b0);

    // Delta across the count wrap.
    doFlush();
    pulseWake(20'hFFFF0, 1'b0);
    pulseWake(20'h00010, 1'b0);
    checkOutput("t2_level", 32'(level), 32'd2);
    checkOutput("t2_head_data", 32'(ifc.ts_data), 32'hFFFF0);
    applyStimulus(1'b1, 1'b0, 20'h0, 1'b0, 1'b1);
    checkOutput("t2_wrap_delta", 32'(ifc.ts_delta), 32'h00020);
    checkOutput("t2_wrap_data", 32'(ifc.ts_data), 32'h00010);

    // Overflow on a stalled reader, cleared by flush.
    doFlush();
    for (int i = 1; i <= 5; i++) pulseWake(20'(i * 32'h111), 1'b0);
    checkOutput("t3_level", 32'(level), 32'd4);
    checkOutput("t3_overflow", 32'(overflow), 32'd1);
    checkOutput("t3_head", 32'(ifc.ts_data), 32'h00111);
    doFlush();
    checkOutput("t3_flush_level", 32'(level), 32'd0);
    checkOutput("t3_flush_ovf", 32'(overflow), 32'd0);

    // Full FIFO with a pop on the push edge.
    for (int i = 1; i <= 4; i++) pulseWake(20'(i * 32'h1010), 1'b0);
    pulseWake(20'h55555, 1'b1);
    checkOutput("t4_level", 32'(level), 32'd4);
    checkOutput("t4_overflow", 32'(overflow), 32'd0);
    checkOutput("t4_head", 32'(ifc.ts_data), 32'h02020);

    // Held-high wakeup and disabled capture.
    doFlush();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 20'h00ABC, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 20'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 20'h0, 1'b0, 1'b0);
    checkOutput("t5_held", 32'(level), 32'd1);
    applyStimulus(1'b0, 1'b0, 20'h00123, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 20'h00123, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 20'h00123, 1'b1, 1'b0);
    checkOutput("t5_en_off", 32'(level), 32'd1);
    applyStimulus(1'b1, 1'b0, 20'h0, 1'b0, 1'b0);

    // Asynchronous reset while draining.
    doFlush();
    for (int i = 1; i <= 3; i++) pulseWake(20'(i * 32'h3000), 1'b0);
    checkOutput("t6_level3", 32'(level), 32'd3);
    @(negedge clk);
    ifc.ts_ready = 1'b1;
    #2;
    clr_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(ifc.ts_valid), 32'd0);
    checkOutput("t6_rst_level", 32'(level), 32'd0);
    checkOutput("t6_rst_data", 32'(ifc.ts_data), 32'd0);
    modelReset();
    ifc.ts_ready = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    pulseWake(20'h7A5C3, 1'b0);
    checkOutput("t6_valid", 32'(ifc.ts_valid), 32'd1);
    checkOutput("t6_delta", 32'(ifc.ts_delta), 32'd0);
    checkOutput("t6_data", 32'(ifc.ts_data), 32'h7A5C3);

    // Randomized traffic.
    wk = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 2) == 0) wk = ~wk;
      b = ($urandom_range(0, 3) == 0) ? (20'hFFFF0 + 20'($urandom_range(0, 31)))
                                      : 20'($urandom);
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 79) == 0,
                    toMixed(b), wk, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
